// File: rtl/bark_pkg.sv
// Shared types and widths for the ALU issue stage.
// Op codes, datapath/register widths and the illegal-op test.
package bark_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_t;

  function automatic logic op_illegal(
    input logic [2:0] op
  );
    return op > ALU_XOR;
  endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// Per-source operand forwarding for the ALU issue stage.
// rs_i/rf_val_i: source index + RF read; s1/s2 valid+rd; alu_result_i, out_result_i -> val_o.
module alu_fwd_mux
  import bark_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  logic [XLEN-1:0]   rf_val_i,
  input  logic              s1_valid_i,
  input  logic [REG_AW-1:0] s1_rd_i,
  input  logic              s2_valid_i,
  input  logic [REG_AW-1:0] s2_rd_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   out_result_i,
  output logic [XLEN-1:0]   val_o
);

  logic rs_nz;
  logic s1_hit;
  logic s2_hit;

  assign rs_nz  = rs_i != '0;
  assign s1_hit = rs_nz && s1_valid_i && (s1_rd_i == rs_i);
  assign s2_hit = rs_nz && s2_valid_i && (s2_rd_i == rs_i);

  // Youngest producer wins: S1 result is still on the ALU output.
  always_comb begin
    val_o = rf_val_i;
    priority case (1'b1)
      s1_hit:  val_o = alu_result_i;
      s2_hit:  val_o = out_result_i;
      default: val_o = rf_val_i;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-stage wrapper: issue register feeding an external ALU, result register to WB.
// in_*: decoded op (valid/ready); alu_control/operand1/2 -> ALU; out_*: result; counters.
module alu_issue_stage
  import bark_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  output logic [31:0]       alu_control,
  output logic [XLEN-1:0]   operand1,
  output logic [XLEN-1:0]   operand2,
  input  logic [XLEN-1:0]   alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_result,
  output logic [CNT_W-1:0]  illegal_cnt,
  output logic [CNT_W-1:0]  retired_cnt
);

  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic [2:0]        op_q;
  logic [REG_AW-1:0] s1_rd_q;
  logic [XLEN-1:0]   op1_q, op2_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   res_q;
  logic [CNT_W-1:0]  ill_q, ret_q;

  logic            s2_ready;
  logic            s1_adv;
  logic            accept;
  logic            retire;
  logic [XLEN-1:0] fwd1, fwd2, op2_sel;

  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_ready;
  assign in_ready = !flush && (!s1_valid_q || s2_ready);
  assign accept   = in_valid && in_ready;
  assign retire   = s2_valid_q && out_ready && !flush;

  alu_fwd_mux u_fwd1 (
    .rs_i         (in_rs1),
    .rf_val_i     (in_rs1_val),
    .s1_valid_i   (s1_valid_q),
    .s1_rd_i      (s1_rd_q),
    .s2_valid_i   (s2_valid_q),
    .s2_rd_i      (rd_q),
    .alu_result_i (alu_result),
    .out_result_i (res_q),
    .val_o        (fwd1)
  );

  alu_fwd_mux u_fwd2 (
    .rs_i         (in_rs2),
    .rf_val_i     (in_rs2_val),
    .s1_valid_i   (s1_valid_q),
    .s1_rd_i      (s1_rd_q),
    .s2_valid_i   (s2_valid_q),
    .s2_rd_i      (rd_q),
    .alu_result_i (alu_result),
    .out_result_i (res_q),
    .val_o        (fwd2)
  );

  assign op2_sel = in_use_imm ? in_imm : fwd2;

  always_comb begin
    s1_valid_d = accept || (s1_valid_q && !s1_adv);
    s2_valid_d = s1_adv || (s2_valid_q && !out_ready);
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      s1_rd_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
    end else if (accept) begin
      op_q    <= in_op;
      s1_rd_q <= in_rd;
      op1_q   <= fwd1;
      op2_q   <= op2_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      res_q <= '0;
    end else if (s1_adv) begin
      rd_q  <= s1_rd_q;
      res_q <= alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_q <= '0;
      ret_q <= '0;
    end else begin
      if (accept && op_illegal(in_op) && (ill_q != '1)) begin
        ill_q <= ill_q + CNT_W'(1);
      end
      if (retire) begin
        ret_q <= ret_q + CNT_W'(1);
      end
    end
  end

  assign alu_control = {29'd0, op_q};
  assign operand1    = op1_q;
  assign operand2    = op2_q;
  assign out_valid   = s2_valid_q;
  assign out_rd      = rd_q;
  assign out_result  = res_q;
  assign illegal_cnt = ill_q;
  assign retired_cnt = ret_q;

endmodule
